mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter and access sequencer for the shared RAM.
// Requester 0 is the controller-side memory port, requester 1 the loader/debug
// port. One requester is granted at a time. Its command is latched, and the RAM
// strobes are driven for a fixed window of WAIT_CYCLES cycles. Completion is
// signalled with a one-cycle done pulse, and the read data is held on rdata.
//
// Parameters
//   AW           address width
//   DW           data width
//   WAIT_CYCLES  cycles ram_ena is held per access (legal range 1..15)
//
// Ports
//   clk                       system clock, rising edge
//   rst                       asynchronous, active-high reset
//   req0/we0/addr0/wdata0     requester 0 command (level, held until done0)
//   gnt0, done0               requester 0 ownership / completion pulse
//   req1/we1/addr1/wdata1     requester 1 command
//   gnt1, done1               requester 1 ownership / completion pulse
//   rdata                     data of the last completed read (shared)
//   ram_ena/read/write        RAM enable and direction strobes
//   ram_addr, ram_wdata       latched RAM address / write data
//   ram_rdata                 RAM read data, valid while ram_ena && ram_read
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW          = 8,
   parameter int DW          = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          done0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          done1,
   output logic [DW-1:0] rdata,
   output logic          ram_ena,
   output logic          ram_read,
   output logic          ram_write,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // The counter is loaded with WAIT_CYCLES-1 on the grant edge. The window
   // ends on the edge where it is found at zero, which gives exactly
   // WAIT_CYCLES cycles of ram_ena.
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic          last_q;       // last granted requester; also the owner while busy
   logic          gnt0_q, gnt1_q;
   logic          done0_q, done1_q;
   logic          ram_ena_q, ram_read_q, ram_write_q;
   logic [AW-1:0] ram_addr_q;
   logic [DW-1:0] ram_wdata_q;
   logic [DW-1:0] rdata_q;

   // Arbitration decode. It is only consumed in IDLE.
   logic          any_req;
   logic          owner_d;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // NOTE: every signal gets a default at the top of the always_comb, so no
   // path through the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      any_req = req0 | req1;
      owner_d = last_q;
      if (req0 && req1) begin
         owner_d = ~last_q;      // tie: the requester not served last wins
      end else if (req0) begin
         owner_d = 1'b0;
      end else if (req1) begin
         owner_d = 1'b1;
      end
      sel_we    = owner_d ? we1    : we0;
      sel_addr  = owner_d ? addr1  : addr0;
      sel_wdata = owner_d ? wdata1 : wdata0;
   end

   // NOTE: all state below is updated with non-blocking assignments. Every
   // register then samples the pre-edge values of the others, regardless of
   // statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         last_q      <= 1'b1;      // requester 0 wins the first tie
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         ram_ena_q   <= 1'b0;
         ram_read_q  <= 1'b0;
         ram_write_q <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         // The done pulses last a single cycle unless re-asserted below.
         done0_q <= 1'b0;
         done1_q <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  state_q     <= S_ACCESS;
                  last_q      <= owner_d;
                  gnt0_q      <= ~owner_d;
                  gnt1_q      <= owner_d;
                  ram_ena_q   <= 1'b1;
                  ram_write_q <= sel_we;
                  ram_read_q  <= ~sel_we;
                  ram_addr_q  <= sel_addr;
                  ram_wdata_q <= sel_wdata;
                  cnt_q       <= CNT_INIT;
               end
            end

            S_ACCESS: begin
               // The latched command is held. Requester inputs are not looked at here.
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  if (ram_read_q) begin
                     rdata_q <= ram_rdata;
                  end
                  ram_ena_q   <= 1'b0;
                  ram_read_q  <= 1'b0;
                  ram_write_q <= 1'b0;
                  gnt0_q      <= 1'b0;
                  gnt1_q      <= 1'b0;
                  done0_q     <= ~last_q;
                  done1_q     <= last_q;
                  state_q     <= S_DONE;
               end
            end

            S_DONE: begin
               // Dead cycle: a request still held is arbitrated again from IDLE.
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign done0     = done0_q;
   assign done1     = done1_q;
   assign rdata     = rdata_q;
   assign ram_ena   = ram_ena_q;
   assign ram_read  = ram_read_q;
   assign ram_write = ram_write_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter.
// - Main instance: WAIT_CYCLES = 3.
// - Second instance: WAIT_CYCLES = 15.
// The stimulus pushes one expected transaction per request. A monitor on the
// falling clock edge does the following:
// - checks the strobes and latched command against the head of the queue
//   during the access window;
// - pops and checks owner, window length and rdata on each done pulse.
// RAM contents come from a fixed bench function (0x12 -> 0xA5, else addr^0x5A).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int WA = 3;
   localparam int WB = 15;

   typedef struct {
      logic       port;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;   // rdata expected once this transaction is done
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT (WAIT_CYCLES = 3) ----------------
   logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
   logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
   logic       gnt0, gnt1, done0, done1, ram_ena, ram_read, ram_write;
   logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;

   function automatic logic [7:0] ram_val(input logic [7:0] a);
      return (a == 8'h12) ? 8'hA5 : (a ^ 8'h5A);
   endfunction

   assign ram_rdata = ram_val(ram_addr);

   mem_arbiter #(.AW(8), .DW(8), .WAIT_CYCLES(WA)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
      .rdata(rdata), .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // ---------------- second DUT (WAIT_CYCLES = 15) ----------------
   logic       req0_b = 0, req1_b = 0, we0_b = 0, we1_b = 0;
   logic [7:0] addr0_b = 0, wdata0_b = 0, addr1_b = 0, wdata1_b = 0;
   logic       gnt0_b, gnt1_b, done0_b, done1_b, ram_ena_b, ram_read_b, ram_write_b;
   logic [7:0] rdata_b, ram_addr_b, ram_wdata_b, ram_rdata_b;

   assign ram_rdata_b = ram_val(ram_addr_b);

   mem_arbiter #(.AW(8), .DW(8), .WAIT_CYCLES(WB)) u_dut15 (
      .clk(clk), .rst(rst),
      .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .gnt0(gnt0_b), .done0(done0_b),
      .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .gnt1(gnt1_b), .done1(done1_b),
      .rdata(rdata_b), .ram_ena(ram_ena_b), .ram_read(ram_read_b), .ram_write(ram_write_b),
      .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   exp_t       sb_q[$];
   logic [7:0] sb_b[$];
   logic [7:0] last_rd = 8'h00;
   int         done_cnt = 0;
   int         done_cnt_b = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic port, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata);
      exp_t e;
      if (!we) last_rd = ram_val(addr);
      e.port  = port;
      e.we    = we;
      e.addr  = addr;
      e.wdata = wdata;
      e.rdata = last_rd;
      sb_q.push_back(e);
   endtask

   // Monitor for the main DUT.
   int   run_len   = 0;
   logic prev_done = 1'b0;
   exp_t mon_e;

   always @(negedge clk) begin
      if (rst) begin
         run_len   = 0;
         prev_done = 1'b0;
      end else begin
         check("excl_gnt", 32'(gnt0 & gnt1), 0);
         check("excl_rw", 32'(ram_read & ram_write), 0);
         if (ram_ena) begin
            run_len++;
            if (sb_q.size() == 0) begin
               check("unexpected_access", 1, 0);
            end else begin
               mon_e = sb_q[0];
               check("gnt_owner", {gnt1, gnt0}, mon_e.port ? 2'b10 : 2'b01);
               check("ram_addr", ram_addr, mon_e.addr);
               check("ram_write", 32'(ram_write), 32'(mon_e.we));
               check("ram_read", 32'(ram_read), 32'(!mon_e.we));
               if (mon_e.we) check("ram_wdata", ram_wdata, mon_e.wdata);
            end
         end else begin
            check("gnt_idle", {gnt1, gnt0}, 0);
         end
         if (done0 || done1) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               mon_e = sb_q.pop_front();
               check("done_owner", {done1, done0}, mon_e.port ? 2'b10 : 2'b01);
               check("ena_len", run_len, WA);
               check("rdata", rdata, mon_e.rdata);
               check("done_single", 32'(prev_done), 0);
            end
            run_len = 0;
            done_cnt++;
         end
         prev_done = done0 | done1;
      end
   end

   // Monitor for the WAIT_CYCLES = 15 DUT.
   int         run_len_b = 0;
   logic [7:0] mon_rd_b;

   always @(negedge clk) begin
      if (rst) begin
         run_len_b = 0;
      end else begin
         check("b_excl_gnt", 32'(gnt0_b & gnt1_b), 0);
         check("b_excl_rw", 32'(ram_read_b & ram_write_b), 0);
         if (ram_ena_b) begin
            run_len_b++;
            check("b_gnt0", {gnt1_b, gnt0_b}, 2'b01);
            check("b_ram_addr", ram_addr_b, 8'h12);
         end
         if (done0_b || done1_b) begin
            if (sb_b.size() == 0) begin
               check("b_unexpected_done", 1, 0);
            end else begin
               mon_rd_b = sb_b.pop_front();
               check("b_done_owner", {done1_b, done0_b}, 2'b01);
               check("b_ena_len", run_len_b, WB);
               check("b_rdata", rdata_b, mon_rd_b);
            end
            run_len_b = 0;
            done_cnt_b++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_dones(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_count", done_cnt, target);
   endtask

   task automatic wait_gnt0(input int budget);
      int n = 0;
      while (!gnt0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("gnt0_seen", 32'(gnt0), 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, {gnt1, gnt0}, 0);
      check({tag, "_done"}, {done1, done0}, 0);
      check({tag, "_strobes"}, {ram_ena, ram_read, ram_write}, 0);
      check({tag, "_ram_addr"}, ram_addr, 0);
      check({tag, "_ram_wdata"}, ram_wdata, 0);
      check({tag, "_rdata"}, rdata, 0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int t_prev;
      int n;

      repeat (2) @(posedge clk);
      #1 check_zero("rst_init");
      @(posedge clk); #3 rst = 1'b0;

      // Single read by requester 0.
      @(posedge clk); #1;
      push_exp(1'b0, 1'b0, 8'h12, 8'h00);
      req0 = 1; we0 = 0; addr0 = 8'h12;
      wait_dones(1, 50);
      req0 = 0;

      // Single write by requester 1; rdata must stay 0xA5.
      push_exp(1'b1, 1'b1, 8'h40, 8'h3C);
      req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 8'h3C;
      wait_dones(2, 50);
      req1 = 0;

      // Fairness: both held for six transactions.
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) push_exp(1'b0, 1'b0, 8'h20, 8'h00);
         else            push_exp(1'b1, 1'b1, 8'h50, 8'h77);
      end
      req0 = 1; we0 = 0; addr0 = 8'h20;
      req1 = 1; we1 = 1; addr1 = 8'h50; wdata1 = 8'h77;
      t_prev = cyc;
      for (int k = 0; k < 6; k++) begin
         wait_dones(3 + k, 50);
         if (k > 0) check("txn_period", cyc - t_prev, WA + 2);
         t_prev = cyc;
      end
      req0 = 0; req1 = 0;

      // Command change and req drop in the middle of an access.
      push_exp(1'b0, 1'b0, 8'h33, 8'h00);
      req0 = 1; we0 = 0; addr0 = 8'h33;
      wait_gnt0(20);
      addr0 = 8'hFF; we0 = 1; wdata0 = 8'hEE; req0 = 0;
      wait_dones(9, 50);

      // Reset in the middle of an access, with cnt at 1 (last = 0 before reset).
      push_exp(1'b0, 1'b0, 8'h44, 8'h00);
      req0 = 1; we0 = 0; addr0 = 8'h44;
      wait_gnt0(20);
      @(posedge clk); #1 rst = 1'b1;
      #1 check_zero("rst_mid");
      sb_q.delete();
      last_rd = 8'h00;
      req0 = 0;
      n = done_cnt;
      @(posedge clk); #1 check_zero("rst_hold");
      @(posedge clk); #3 rst = 1'b0;
      check("rst_no_done", done_cnt, n);

      // After reset both requesters ask at once: requester 0 must win first.
      @(posedge clk); #1;
      push_exp(1'b0, 1'b0, 8'h12, 8'h00);
      push_exp(1'b1, 1'b0, 8'h21, 8'h00);
      req0 = 1; we0 = 0; addr0 = 8'h12;
      req1 = 1; we1 = 0; addr1 = 8'h21;
      wait_dones(n + 2, 60);
      req0 = 0; req1 = 0;

      // Long window: WAIT_CYCLES = 15 read.
      sb_b.push_back(8'hA5);
      req0_b = 1; we0_b = 0; addr0_b = 8'h12;
      n = 0;
      while (done_cnt_b < 1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("b_done_count", done_cnt_b, 1);
      req0_b = 0;

      repeat (4) @(posedge clk);
      #1;
      check("sb_empty", sb_q.size(), 0);
      check("sb_b_empty", sb_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
      $fatal(1, "watchdog");
   end

endmodule
